// File: rtl/adder45_share_arbiter.sv
// Round-robin arbiter that time-shares one 45+42-bit adder among NUM_REQ requesters.
// A single registered result slot with valid/ready faces the consumer.

module customAdder45_3 (
    input  logic [44:0] a,
    input  logic [41:0] b,
    output logic [45:0] sum
);
    assign sum = 46'(a) + 46'(b);
endmodule

module adder45_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*45-1:0] req_a,
    input  logic [NUM_REQ*42-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [45:0]           res_sum,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);
    localparam int unsigned A_W = 45;
    localparam int unsigned B_W = 42;
    localparam int unsigned S_W = 46;

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] gidx;
    logic            found;
    logic            can_accept;
    logic            xfer;
    logic            pop;
    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;
    logic [S_W-1:0]  sum;
    logic [31:0]     idx;

    // First valid requester after last_grant, wrapping around.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                gidx  = ID_W'(idx);
            end
        end
    end

    assign can_accept = !res_valid || res_ready;
    assign req_ready  = (rst_n && can_accept && found) ? (NUM_REQ'(1) << gidx) : '0;
    assign xfer       = |req_ready;
    assign pop        = res_valid && res_ready;
    assign busy       = res_valid || (|req_valid);

    // Operand mux feeding the shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx == ID_W'(i)) begin
                a_sel = req_a[i*A_W +: A_W];
                b_sel = req_b[i*B_W +: B_W];
            end
        end
    end

    customAdder45_3 u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum)
    );

    // Result slot: a push wins over a pop so back-to-back results have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (xfer) begin
            res_valid  <= 1'b1;
            res_sum    <= sum;
            res_id     <= gidx;
            last_grant <= gidx;
        end else if (pop) begin
            res_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (pop && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/adder45_share_arbiter.md
Name: adder45_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one customAdder45_3 datapath (45-bit A plus 42-bit B zero-extended, 46-bit sum) among NUM_REQ requesters in the multiplier partial-product accumulation path.
- Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and drives the shared adder with that pair.
- The sum and the requester index go into a single output register with a valid/ready handshake toward the consumer.
- A saturating operation counter supports performance observation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_a  input  NUM_REQ*45  flattened A operands; requester i uses bits [45*i+44 : 45*i].
- req_b  input  NUM_REQ*42  flattened B operands; requester i uses bits [42*i+41 : 42*i].
- res_valid  output  1  output register holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  46  registered sum A + {3'b0,B}.
- res_id  output  ID_W  index of the requester that produced res_sum.
- busy  output  1  res_valid OR any req_valid.
- op_count  output  CNT_W  completed handshakes on the result port, saturating.

Behaviour:
- Datapath:
  - Exactly one customAdder45_3 instance.
  - Operands come from a NUM_REQ-way mux selected by the current grant index.
  - Sum is 46 bits, unsigned; no overflow is possible; bit 45 is the carry out.
- Accept condition: can_accept = !res_valid OR res_ready.
- Grant:
  - When can_accept=1, scan req_valid starting at index (last_grant+1) mod NUM_REQ and wrap. The first set bit is g.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - When can_accept=0 or no req_valid bit is set, req_ready=0.
- Transfer: a handshake on requester g occurs when req_valid[g] & req_ready[g]. On that clock edge:
  - res_sum <= adder output for g's operands;
  - res_id <= g;
  - res_valid <= 1;
  - last_grant <= g.
- Latency is 1 cycle from the accept edge to res_valid.
- Throughput is 1 result per cycle when res_ready is held high.
- Result hold: while res_valid=1 and res_ready=0, res_sum, res_id and res_valid hold stable and req_ready=0.
- Simultaneous pop and push: if res_valid & res_ready and a new grant occurs in the same cycle, the register loads the new result and res_valid stays 1 (no bubble).
- Pop without push: res_valid <= 0; res_sum and res_id keep their old values (don't-care).
- last_grant updates only on a handshake, never on a mere request. A requester that drops req_valid before being granted loses nothing.
- Requesters must hold req_a, req_b and req_valid stable until granted. req_ready depends combinationally on req_valid, so requesters must not make req_valid depend on req_ready.
- op_count:
  - Increments on each result handshake (res_valid & res_ready).
  - Saturates at all-ones.
  - Does not increment on the cycle a reset is asserted.
- Reset (asynchronous, any time, including mid-transfer), required values:
  - res_valid=0, res_sum=0, res_id=0, op_count=0;
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset;
  - the in-flight result is discarded;
  - req_ready=0 while rst_n=0.
- Fairness: with all requesters continuously valid and res_ready=1, grants cycle 0,1,2,3,0... Each requester waits at most NUM_REQ-1 grants.

Test Plan:
- Reset then single request:
  - Stimulus: req 2 valid with A=45'h1FFF_FFFF_FFFF, B=42'h3FF_FFFF_FFFF, res_ready=1.
  - Required: req_ready=4'b0100 in that cycle. Next cycle res_valid=1, res_sum=46'h23FF_FFFF_FFFE, res_id=2, op_count=1 after the pop.
- Round robin:
  - Stimulus: all 4 requesters valid continuously with A=i+1, B=10*(i+1), res_ready=1.
  - Required: res_id sequence 0,1,2,3,0 on consecutive cycles; res_sum 11,22,33,44; no idle cycles.
- Backpressure:
  - Stimulus: res_ready=0 for 3 cycles with req 1 and req 3 valid.
  - Required: res_valid=1 with the first result held stable and req_ready=0 throughout. After res_ready rises, the next grant goes to the requester after last_grant, and the handoff has zero bubbles.
- Wrap-around and late requester:
  - Stimulus: last_grant=3; req 0 and req 3 both valid.
  - Required: grant to 0 first, then 3. Separately, a request that drops before grant is never granted.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while res_valid=1 and res_ready=0.
  - Required: res_valid=0 and op_count=0 immediately, without waiting for a clock edge. After release, requester 0 wins against 0 and 2 simultaneously valid.
- Counter saturation (CNT_W=4): after 20 handshakes, op_count=4'hF and it stays there.
